// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the signed restoring divider
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic int div_cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int DIV_CNT_W = div_cnt_w(DIV_WIDTH);

    // Divide-by-zero quotient is all ones; sliced to the operand width at use.
    localparam logic [63:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: shift {R,Q}, trial subtract |B|
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH+1:0] r_sh;
    logic [WIDTH+1:0] trial;
    logic             ge;

    // One extra bit above R keeps the trial sign available after the subtract.
    always_comb begin
        r_sh   = {r, q[WIDTH-1]};
        trial  = r_sh - {2'b00, b};
        ge     = ~trial[WIDTH+1];
        q_next = {q[WIDTH-2:0], ge};
        r_next = ge ? trial[WIDTH:0] : r_sh[WIDTH:0];
    end

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - sequential signed divider, one quotient bit per cycle, RISC-V DIV/REM results
// Optional DIVIDER_FAST_ZERO_EN: zero divisor or zero dividend finishes one cycle after accept.
module divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               finish,
    output logic [2*WIDTH-1:0] res
);

    localparam int CNT_W = div_cnt_w(WIDTH);

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] a_keep;
    logic             qsign;
    logic             rsign;
    logic             dz;

    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] a_abs_in;
    logic [WIDTH-1:0] b_abs_in;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic             last;

`ifdef DIVIDER_FAST_ZERO_EN
    logic             az;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_q),
        .q      (q_q),
        .b      (b_abs),
        .r_next (r_next),
        .q_next (q_next)
    );

    // Negation wraps, so the most negative operand maps to itself read as unsigned.
    always_comb begin
        a_abs_in = A[WIDTH-1] ? -A : A;
        b_abs_in = B[WIDTH-1] ? -B : B;
        quo_fix  = qsign ? -q_next : q_next;
        rem_fix  = rsign ? -r_next[WIDTH-1:0] : r_next[WIDTH-1:0];
`ifdef DIVIDER_FAST_ZERO_EN
        last     = (cnt == CNT_W'(WIDTH - 1)) || dz || az;
`else
        last     = (cnt == CNT_W'(WIDTH - 1));
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            r_q    <= '0;
            q_q    <= '0;
            b_abs  <= '0;
            a_keep <= '0;
            qsign  <= 1'b0;
            rsign  <= 1'b0;
            dz     <= 1'b0;
`ifdef DIVIDER_FAST_ZERO_EN
            az     <= 1'b0;
`endif
            finish <= 1'b0;
            res    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        r_q    <= '0;
                        q_q    <= a_abs_in;
                        b_abs  <= b_abs_in;
                        a_keep <= A;
                        qsign  <= A[WIDTH-1] ^ B[WIDTH-1];
                        rsign  <= A[WIDTH-1];
                        dz     <= (B == '0);
`ifdef DIVIDER_FAST_ZERO_EN
                        az     <= (A == '0);
`endif
                        cnt    <= '0;
                        finish <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    r_q <= r_next;
                    q_q <= q_next;
                    cnt <= cnt + CNT_W'(1);
                    // A zero dividend yields zero from the datapath after any step count.
                    if (last) begin
                        res    <= dz ? {a_keep, DZ_QUOTIENT[WIDTH-1:0]} : {rem_fix, quo_fix};
                        finish <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - self-checking bench for divider: directed table, random vs model, corner sequences
module tb_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        finish;
    logic [63:0] res;

    int n_vec = 0;
    int n_bad = 0;

`ifdef DIVIDER_FAST_ZERO_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    divider #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (A),
        .B      (B),
        .finish (finish),
        .res    (res)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0)
            return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
        return (FAST && (a == 32'd0 || b == 32'd0)) ? 1 : 32;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (finish) break;
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] ra;
        logic [31:0] rb;

        tbl[0]  = '{32'd100,       32'd7,         32'd14,        32'd2};
        tbl[1]  = '{32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE};
        tbl[2]  = '{32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2};
        tbl[3]  = '{32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5};
        tbl[4]  = '{32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFB};
        tbl[5]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        tbl[6]  = '{32'd7,         32'd100,       32'd0,         32'd7};
        tbl[7]  = '{32'd0,         32'd5,         32'd0,         32'd0};
        tbl[8]  = '{32'd6,         32'd4,         32'd1,         32'd2};
        tbl[9]  = '{32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0};
        tbl[10] = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF};
        tbl[11] = '{32'd0,         32'd0,         32'hFFFF_FFFF, 32'd0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_finish", 64'(finish), 64'd0);
        check("reset_res", res, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_div(tbl[i].a, tbl[i].b, lat);
            check($sformatf("tbl%0d_res", i), res, {tbl[i].r, tbl[i].q});
            check($sformatf("tbl%0d_lat", i), 64'(lat), 64'(exp_lat(tbl[i].a, tbl[i].b)));
        end

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: rb = ~$urandom_range(0, 14);
                3: begin rb = 32'hFFFF_FFFF; ra = 32'h8000_0000; end
                4: begin rb = $urandom; ra = 32'd0; end
                default: rb = $urandom;
            endcase
            run_div(ra, rb, lat);
            check($sformatf("rnd%0d_res a=%h b=%h", i, ra, rb), res, model(ra, rb));
            check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(exp_lat(ra, rb)));
        end

        // start pulsed mid-run must be ignored
        @(negedge clk);
        A = 32'd100;
        B = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 10) begin
                A = 32'd9;
                B = 32'd3;
                start = 1'b1;
            end else if (lat == 11) begin
                start = 1'b0;
            end
            if (finish) break;
        end
        check("ignore_res", res, {32'd2, 32'd14});
        check("ignore_lat", 64'(lat), 64'd32);

        // start held in DONE: accepted next edge, finish drops, old res kept
        A = 32'd9;
        B = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("redo_finish_drop", 64'(finish), 64'd0);
        check("redo_res_kept", res, {32'd2, 32'd14});
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (finish) break;
        end
        check("redo_res", res, {32'd0, 32'd3});
        check("redo_lat", 64'(lat), 64'd32);

        // asynchronous reset mid-run
        @(negedge clk);
        A = 32'd100;
        B = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_finish", 64'(finish), 64'd0);
        check("arst_res", res, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div(32'd6, 32'd4, lat);
        check("post_rst_res", res, {32'd2, 32'd1});
        check("post_rst_lat", 64'(lat), 64'd32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
